sc_stream_to_bin: RTL and testbench

Stochastic-to-binary converter: the consuming end of the SC datapath. It accepts the 2-bit stochastic lanes produced by the SC select/scaled-add stage. It counts ones per lane over a fixed window of 2^LEN_LOG2 valid beats, then presents the binary counts with a valid/ready handshake. It sits between the SC processing element outputs and the CGRA's binary result registers.

---
 rtl/sc_pkg.sv | 18 +
 rtl/sc_ones_counter.sv | 25 ++
 rtl/sc_stream_to_bin.sv | 84 ++++++++
 tb/tb_sc_stream_to_bin.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared types and constants for the stochastic-computing (SC) datapath.
package sc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } sc_state_e;

  localparam int SC_LANES    = 2;
  localparam int SC_LEN_LOG2 = 8;

  // A lane count must hold the full window length 2^len_log2, hence one extra bit.
  function automatic int sc_cnt_w(input int len_log2);
    return len_log2 + 1;
  endfunction

endpackage

// File: rtl/sc_ones_counter.sv
// Single-lane ones counter. It exposes both the current count and the count
// that would result from accepting bit_in this cycle. The top uses the second
// value to capture a window result that includes the final beat.
module sc_ones_counter #(
  parameter int CW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic          bit_in,
  output logic [CW-1:0] cnt,
  output logic [CW-1:0] cnt_nxt
);

  assign cnt_nxt = cnt + CW'(bit_in);

  // Clear has priority so that a restart never picks up a stray beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt_nxt;
  end

endmodule

// File: rtl/sc_stream_to_bin.sv
// Stochastic-to-binary converter. It counts ones per lane over 2^LEN_LOG2 valid
// beats, then holds the binary counts behind a valid/ready handshake.
module sc_stream_to_bin
  import sc_pkg::*;
#(
  parameter int LANES    = SC_LANES,
  parameter int LEN_LOG2 = SC_LEN_LOG2,
  localparam int CW      = sc_cnt_w(LEN_LOG2)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [LANES-1:0]    bit_in,
  input  logic                bit_valid,
  output logic                busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*CW-1:0] count_out
);

  sc_state_e                     state, state_nxt;
  logic [LEN_LOG2-1:0]           beat_cnt;
  logic [LANES-1:0][CW-1:0]      lane_cnt, lane_nxt;
  logic                          clr, acc_en, last_beat, hshake;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. The window ends on the beat that wraps the beat counter.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = ACCUM;
      ACCUM:   if (last_beat) state_nxt = HOLD;
      HOLD:    if (hshake)    state_nxt = start ? ACCUM : IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Datapath controls decoded from the current state.
  always_comb begin
    acc_en    = (state == ACCUM) && bit_valid;
    last_beat = acc_en && (beat_cnt == '1);
    hshake    = (state == HOLD) && out_ready;
    clr       = ((state == IDLE) && start) || (hshake && start);
  end

  // Beat counter. It wraps to zero naturally on the last beat of a window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      beat_cnt <= '0;
    else if (clr)    beat_cnt <= '0;
    else if (acc_en) beat_cnt <= beat_cnt + 1'b1;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sc_ones_counter #(.CW(CW)) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .en      (acc_en),
      .bit_in  (bit_in[i]),
      .cnt     (lane_cnt[i]),
      .cnt_nxt (lane_nxt[i])
    );
  end

  // Registered outputs. The result is captured with the last beat included,
  // and the status flags track the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      out_valid <= 1'b0;
      count_out <= '0;
    end else begin
      busy      <= (state_nxt != IDLE);
      out_valid <= (state_nxt == HOLD);
      if (last_beat) count_out <= lane_nxt;
    end
  end

endmodule

// File: tb/tb_sc_stream_to_bin.sv
// Bench for sc_stream_to_bin. Instance A uses a short 16-beat window for the
// directed and random scenarios. Instance B uses the default 256-beat window.
module tb_sc_stream_to_bin;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, start_a, bv_a, rdy_a, busy_a, ov_a;
  logic [1:0] bin_a;
  logic [9:0] count_a;
  logic       rst_b, start_b, bv_b, rdy_b, busy_b, ov_b;
  logic [1:0] bin_b;
  logic [17:0] count_b;

  sc_stream_to_bin #(.LANES(2), .LEN_LOG2(4)) dut_a (
    .clk(clk), .rst_n(rst_a), .start(start_a), .bit_in(bin_a), .bit_valid(bv_a),
    .busy(busy_a), .out_valid(ov_a), .out_ready(rdy_a), .count_out(count_a)
  );

  sc_stream_to_bin #(.LANES(2), .LEN_LOG2(8)) dut_b (
    .clk(clk), .rst_n(rst_b), .start(start_b), .bit_in(bin_b), .bit_valid(bv_b),
    .busy(busy_b), .out_valid(ov_b), .out_ready(rdy_b), .count_out(count_b)
  );

  int checks   = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model. mode: 0 idle, 1 counting a window, 2 presenting a result.
  int m_mode [2];
  int m_beats[2];
  int m_ones [2][2];
  int m_res  [2][2];

  function automatic void m_reset(input int k);
    m_mode[k] = 0; m_beats[k] = 0;
    for (int l = 0; l < 2; l++) begin m_ones[k][l] = 0; m_res[k][l] = 0; end
  endfunction

  function automatic void m_restart(input int k);
    m_mode[k] = 1; m_beats[k] = 0;
    for (int l = 0; l < 2; l++) m_ones[k][l] = 0;
  endfunction

  function automatic void m_step(input int k, input logic st, input logic bv,
                                 input logic [1:0] b, input logic rdy, input int win);
    if (m_mode[k] == 0) begin
      if (st) m_restart(k);
    end else if (m_mode[k] == 1) begin
      if (bv) begin
        for (int l = 0; l < 2; l++) m_ones[k][l] += int'(b[l]);
        m_beats[k]++;
        if (m_beats[k] == win) begin
          for (int l = 0; l < 2; l++) m_res[k][l] = m_ones[k][l];
          m_mode[k] = 2;
        end
      end
    end else begin
      if (rdy) begin
        if (st) m_restart(k);
        else    m_mode[k] = 0;
      end
    end
  endfunction

  always @(posedge clk or negedge rst_a)
    if (!rst_a) m_reset(0);
    else        m_step(0, start_a, bv_a, bin_a, rdy_a, 16);

  always @(posedge clk or negedge rst_b)
    if (!rst_b) m_reset(1);
    else        m_step(1, start_b, bv_b, bin_b, rdy_b, 256);

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("a_busy",  int'(busy_a), int'(m_mode[0] != 0));
      chk("a_valid", int'(ov_a),   int'(m_mode[0] == 2));
      chk("a_lane0", int'(count_a[4:0]), m_res[0][0]);
      chk("a_lane1", int'(count_a[9:5]), m_res[0][1]);
      chk("b_busy",  int'(busy_b), int'(m_mode[1] != 0));
      chk("b_valid", int'(ov_b),   int'(m_mode[1] == 2));
      chk("b_lane0", int'(count_b[8:0]),  m_res[1][0]);
      chk("b_lane1", int'(count_b[17:9]), m_res[1][1]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic lane0_bits[256];
  logic lane1_bits[256];

  initial begin
    rst_a = 1'b0; start_a = 1'b0; bv_a = 1'b0; rdy_a = 1'b0; bin_a = 2'b00;
    rst_b = 1'b0; start_b = 1'b0; bv_b = 1'b0; rdy_b = 1'b0; bin_b = 2'b00;
    repeat (3) cyc();
    chk("rst_busy_a",  int'(busy_a), 0);
    chk("rst_valid_a", int'(ov_a), 0);
    chk("rst_count_a", int'(count_a), 0);
    chk("rst_count_b", int'(count_b), 0);
    rst_a = 1'b1; rst_b = 1'b1;
    cmp_en = 1'b1;
    cyc();

    // 1: all-ones window of 16 beats
    start_a = 1'b1; cyc(); start_a = 1'b0;
    bv_a = 1'b1; bin_a = 2'b11;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("t1_valid_early", int'(ov_a), 0);
      cyc();
    end
    bv_a = 1'b0;
    chk("t1_valid", int'(ov_a), 1);
    chk("t1_lane0", int'(count_a[4:0]), 16);
    chk("t1_lane1", int'(count_a[9:5]), 16);
    chk("t1_model", m_res[0][0], 16);
    rdy_a = 1'b1; cyc(); rdy_a = 1'b0;
    chk("t1_idle", int'(busy_a), 0);

    // 2: sparse valid beats, lane0 alternating, lane1 zero
    start_a = 1'b1; cyc(); start_a = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bv_a  = (i % 2 == 0);
      bin_a = {1'b0, ((i / 2) % 2 == 0)};
      if (i == 30) chk("t2_valid_early", int'(ov_a), 0);
      if (i == 31) chk("t2_valid", int'(ov_a), 1);
      cyc();
    end
    chk("t2_lane0", int'(count_a[4:0]), 8);
    chk("t2_lane1", int'(count_a[9:5]), 0);
    chk("t2_model", m_res[0][0], 8);

    // 3: back-pressure with beats and start ignored, then restart on handshake
    rdy_a = 1'b0; bv_a = 1'b1; start_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bin_a = 2'($urandom);
      cyc();
      chk("t3_hold_valid", int'(ov_a), 1);
      chk("t3_hold_lane0", int'(count_a[4:0]), 8);
      chk("t3_hold_lane1", int'(count_a[9:5]), 0);
    end
    bv_a = 1'b0; rdy_a = 1'b1; cyc();
    rdy_a = 1'b0; start_a = 1'b0;
    chk("t3_busy", int'(busy_a), 1);
    chk("t3_valid", int'(ov_a), 0);

    // 4: asynchronous reset in the middle of a window
    bv_a = 1'b1; bin_a = 2'b11;
    repeat (7) cyc();
    bv_a = 1'b0;
    #2 rst_a = 1'b0;
    #1;
    chk("t4_busy", int'(busy_a), 0);
    chk("t4_valid", int'(ov_a), 0);
    chk("t4_count", int'(count_a), 0);
    @(posedge clk); #3 rst_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bv_a = 1'($urandom); bin_a = 2'($urandom);
      cyc();
      chk("t4_stay_idle", int'(busy_a), 0);
    end
    bv_a = 1'b0;

    // Random traffic on the short window, checked every cycle by the model
    for (int i = 0; i < 800; i++) begin
      start_a = ($urandom % 4 == 0);
      bv_a    = ($urandom % 4 != 0);
      bin_a   = 2'($urandom);
      rdy_a   = 1'($urandom);
      cyc();
    end
    start_a = 1'b0; bv_a = 1'b0; rdy_a = 1'b1;
    repeat (2) cyc();
    rdy_a = 1'b0;

    // 5: default window, shuffled lanes with 96 and 200 ones, random stalls
    for (int j = 0; j < 256; j++) begin
      lane0_bits[j] = (j < 96);
      lane1_bits[j] = (j < 200);
    end
    for (int j = 255; j > 0; j--) begin
      int r;
      logic t;
      r = int'($urandom_range(j, 0));
      t = lane0_bits[j]; lane0_bits[j] = lane0_bits[r]; lane0_bits[r] = t;
      r = int'($urandom_range(j, 0));
      t = lane1_bits[j]; lane1_bits[j] = lane1_bits[r]; lane1_bits[r] = t;
    end
    start_b = 1'b1; cyc(); start_b = 1'b0;
    begin
      int j;
      int guard;
      j = 0; guard = 0;
      while (j < 256 && guard < 2000) begin
        bv_b = ($urandom % 3 != 0);
        if (j == 255) bv_b = 1'b1;
        bin_b = bv_b ? {lane1_bits[j], lane0_bits[j]} : 2'($urandom);
        if (bv_b) j++;
        guard++;
        cyc();
      end
      chk("t5_beats_sent", j, 256);
    end
    bv_b = 1'b0;
    chk("t5_valid", int'(ov_b), 1);
    chk("t5_lane0", int'(count_b[8:0]), 96);
    chk("t5_lane1", int'(count_b[17:9]), 200);
    chk("t5_model", m_res[1][1], 200);
    rdy_b = 1'b1; cyc(); rdy_b = 1'b0;
    chk("t5_idle_busy", int'(busy_b), 0);
    chk("t5_idle_valid", int'(ov_b), 0);

    repeat (2) cyc();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
